// File: rtl/enemy_bullet_pool.sv
// Enemy bullet pool: NUM_BULLETS slots launched on refresh_tick, stepped each frame, killed by bounds/hit/tank_detroyed.
// Latency: launch, move and kill show one clk_50MHz edge after the qualifying cycle; bullet_on is combinational.
// Backpressure: a fire request stays pending while cooldown runs or all slots are busy; ENEMY_BULLET_AUTOFIRE_EN self-fires.
module enemy_bullet_pool #(
    parameter int NUM_BULLETS  = 4,
    parameter int BULLET_SPEED = 4,
    parameter int BULLET_SIZE  = 4,
    parameter int COOLDOWN     = 30,
    parameter int X_MIN        = 28,
    parameter int X_MAX        = 607,
    parameter int Y_MIN        = 28,
    parameter int Y_MAX        = 447
) (
    input  logic                      clk_50MHz,
    input  logic                      reset,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic                      refresh_tick,
    input  logic                      fire,
    input  logic [3:0]                dir,
    input  logic [9:0]                x_enemy,
    input  logic [9:0]                y_enemy,
    input  logic [NUM_BULLETS-1:0]    hit,
    input  logic                      tank_detroyed,
    output logic [NUM_BULLETS-1:0]    active,
    output logic [10*NUM_BULLETS-1:0] x_bullet,
    output logic [10*NUM_BULLETS-1:0] y_bullet,
    output logic                      fire_ack,
    output logic                      bullet_on
);
    typedef enum logic {IDLE = 1'b0, FLIGHT = 1'b1} slot_state_t;

    localparam int                CW         = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [9:0]        LAUNCH_OFS = 10'(16 - BULLET_SIZE / 2);
    localparam logic signed [10:0] SPEED     = 11'(BULLET_SPEED);
    localparam logic signed [10:0] XMIN      = 11'(X_MIN);
    localparam logic signed [10:0] XMAX      = 11'(X_MAX);
    localparam logic signed [10:0] YMIN      = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX      = 11'(Y_MAX);
    localparam logic [10:0]       SIZE_M1    = 11'(BULLET_SIZE - 1);

    slot_state_t       state_q [NUM_BULLETS];
    slot_state_t       state_d [NUM_BULLETS];
    logic [9:0]        x_q     [NUM_BULLETS];
    logic [9:0]        x_d     [NUM_BULLETS];
    logic [9:0]        y_q     [NUM_BULLETS];
    logic [9:0]        y_d     [NUM_BULLETS];
    logic [3:0]        dir_q   [NUM_BULLETS];
    logic [3:0]        dir_d   [NUM_BULLETS];
    logic signed [10:0] step_x [NUM_BULLETS];
    logic signed [10:0] step_y [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] in_bounds;
    logic [NUM_BULLETS-1:0] free;

    logic          pending_q, pending_d;
    logic [CW-1:0] cool_q, cool_d;
    logic          fire_req;
    logic          attempt, launch, drop;
    logic          claimed;

    // Only slots idle in registered state and not being hit may take a launch,
    // so a slot freed on this tick waits for the next one.
    always_comb begin
        free = '0;
        for (int i = 0; i < NUM_BULLETS; i++)
            free[i] = (state_q[i] == IDLE) && !hit[i];
        attempt = refresh_tick && pending_q && (cool_q == '0) && (free != '0) && !tank_detroyed;
        launch  = attempt && $onehot(dir);
        drop    = attempt && !$onehot(dir);
    end

    // 11-bit signed step so that moving up/left past zero reads as out of bounds.
    always_comb begin
        in_bounds = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            step_x[i] = $signed({1'b0, x_q[i]});
            step_y[i] = $signed({1'b0, y_q[i]});
            if (dir_q[i][3])      step_y[i] = step_y[i] - SPEED;
            else if (dir_q[i][2]) step_y[i] = step_y[i] + SPEED;
            else if (dir_q[i][1]) step_x[i] = step_x[i] - SPEED;
            else if (dir_q[i][0]) step_x[i] = step_x[i] + SPEED;
            in_bounds[i] = (step_x[i] >= XMIN) && (step_x[i] <= XMAX) &&
                           (step_y[i] >= YMIN) && (step_y[i] <= YMAX);
        end
    end

    always_comb begin
        claimed = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            dir_d[i]   = dir_q[i];
            if (tank_detroyed || hit[i]) begin
                state_d[i] = IDLE;
            end else if (state_q[i] == FLIGHT) begin
                if (refresh_tick) begin
                    if (in_bounds[i]) begin
                        x_d[i] = step_x[i][9:0];
                        y_d[i] = step_y[i][9:0];
                    end else begin
                        state_d[i] = IDLE;
                    end
                end
            end else if (launch && !claimed) begin
                claimed    = 1'b1;
                state_d[i] = FLIGHT;
                x_d[i]     = x_enemy + LAUNCH_OFS;
                y_d[i]     = y_enemy + LAUNCH_OFS;
                dir_d[i]   = dir;
            end
        end
    end

    always_comb begin
`ifdef ENEMY_BULLET_AUTOFIRE_EN
        fire_req = (cool_q == '0) && !tank_detroyed;
`else
        fire_req = fire;
`endif
        pending_d = pending_q;
        cool_d    = cool_q;
        if (tank_detroyed) begin
            pending_d = 1'b0;
            cool_d    = '0;
        end else begin
            if (launch || drop)
                pending_d = 1'b0;
            else if (fire_req)
                pending_d = 1'b1;
            if (launch)
                cool_d = CW'(COOLDOWN);
            else if (refresh_tick && (cool_q != '0))
                cool_d = cool_q - 1'b1;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                state_q[i] <= IDLE;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                dir_q[i]   <= '0;
            end
            pending_q <= 1'b0;
            cool_q    <= '0;
            fire_ack  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                dir_q[i]   <= dir_d[i];
            end
            pending_q <= pending_d;
            cool_q    <= cool_d;
            fire_ack  <= launch;
        end
    end

    always_comb begin
        active    = '0;
        x_bullet  = '0;
        y_bullet  = '0;
        bullet_on = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            active[i]             = (state_q[i] == FLIGHT);
            x_bullet[10*i +: 10]  = x_q[i];
            y_bullet[10*i +: 10]  = y_q[i];
            if (active[i] &&
                ({1'b0, x} >= {1'b0, x_q[i]}) && ({1'b0, x} <= {1'b0, x_q[i]} + SIZE_M1) &&
                ({1'b0, y} >= {1'b0, y_q[i]}) && ({1'b0, y} <= {1'b0, y_q[i]} + SIZE_M1))
                bullet_on = 1'b1;
        end
    end

endmodule

// File: tb/tb_enemy_bullet_pool.sv
// Bench for enemy_bullet_pool (COOLDOWN=2): per-cycle vector table through a scoreboard queue, plus reset sequences.
module tb_enemy_bullet_pool;
    localparam int NB = 4;
    localparam logic [3:0] N   = 4'b0000;
    localparam logic [3:0] R   = 4'b0001;
    localparam logic [3:0] U   = 4'b1000;
    localparam logic [3:0] BAD = 4'b0110;

    logic              clk_50MHz = 1'b0;
    logic              reset;
    logic [9:0]        x, y, x_enemy, y_enemy;
    logic              refresh_tick, fire, tank_detroyed;
    logic [3:0]        dir;
    logic [NB-1:0]     hit;
    logic [NB-1:0]     active;
    logic [10*NB-1:0]  x_bullet, y_bullet;
    logic              fire_ack, bullet_on;

    enemy_bullet_pool #(.NUM_BULLETS(NB), .COOLDOWN(2)) dut (
        .clk_50MHz(clk_50MHz), .reset(reset), .x(x), .y(y),
        .refresh_tick(refresh_tick), .fire(fire), .dir(dir),
        .x_enemy(x_enemy), .y_enemy(y_enemy), .hit(hit),
        .tank_detroyed(tank_detroyed), .active(active),
        .x_bullet(x_bullet), .y_bullet(y_bullet),
        .fire_ack(fire_ack), .bullet_on(bullet_on)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    typedef struct {
        logic       rt, fire, tank;
        logic [3:0] dir, hit;
        logic [9:0] xe, ye, px, py;
        logic [3:0] ea;
        logic       ek, eon;
        int         sl;
        logic [9:0] ex, ey;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rt, input logic fr, input logic [3:0] d, input logic [3:0] h,
                                input logic tk, input int xe, input int ye, input logic [3:0] ea,
                                input logic ek, input int sl = -1, input int ex = 0, input int ey = 0,
                                input int px = 0, input int py = 0, input logic eon = 1'b0);
        vec_t v;
        v.rt = rt; v.fire = fr; v.dir = d; v.hit = h; v.tank = tk;
        v.xe = 10'(xe); v.ye = 10'(ye); v.ea = ea; v.ek = ek; v.sl = sl;
        v.ex = 10'(ex); v.ey = 10'(ey); v.px = 10'(px); v.py = 10'(py); v.eon = eon;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        refresh_tick = v.rt; fire = v.fire; dir = v.dir; hit = v.hit; tank_detroyed = v.tank;
        x_enemy = v.xe; y_enemy = v.ye; x = v.px; y = v.py;
        sb.push_back(v);
        @(negedge clk_50MHz);
        e = sb.pop_front();
        chk("active", idx, 64'(active), 64'(e.ea));
        chk("fire_ack", idx, 64'(fire_ack), 64'(e.ek));
        chk("bullet_on", idx, 64'(bullet_on), 64'(e.eon));
        if (e.sl >= 0) begin
            chk("x_bullet", idx, 64'(x_bullet[10*e.sl +: 10]), 64'(e.ex));
            chk("y_bullet", idx, 64'(y_bullet[10*e.sl +: 10]), 64'(e.ey));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; refresh_tick = 1'b0; fire = 1'b0; tank_detroyed = 1'b0;
        dir = N; hit = '0; x = '0; y = '0; x_enemy = '0; y_enemy = '0;
        #25;
        chk("rst_active", -1, 64'(active), 64'd0);
        chk("rst_x_bullet", -1, 64'(x_bullet), 64'd0);
        chk("rst_y_bullet", -1, 64'(y_bullet), 64'd0);
        chk("rst_fire_ack", -1, 64'(fire_ack), 64'd0);
        chk("rst_bullet_on", -1, 64'(bullet_on), 64'd0);
        @(negedge clk_50MHz);
        reset = 1'b1;

        // rightward launch, movement and pixel hit-test edges
        vecs.push_back(mk(0,1,R,N,0,100,50,4'b0000,0));
        vecs.push_back(mk(1,0,R,N,0,100,50,4'b0001,1,0,114,64,114,68,0));
        vecs.push_back(mk(0,0,R,N,0,100,50,4'b0001,0,0,114,64,117,67,1));
        vecs.push_back(mk(1,0,R,N,0,100,50,4'b0001,0,0,118,64,122,64,0));
        vecs.push_back(mk(1,0,R,N,0,100,50,4'b0001,0,0,122,64,125,67,1));
        vecs.push_back(mk(1,0,R,N,0,100,50,4'b0001,0,0,126,64,126,64,1));
        vecs.push_back(mk(0,0,R,N,1,100,50,4'b0000,0,0,126,64,126,64,0));
        // upward launch at the top edge leaves the field on the next tick
        vecs.push_back(mk(0,1,U,N,0,100,14,4'b0000,0));
        vecs.push_back(mk(1,0,U,N,0,100,14,4'b0001,1,0,114,28));
        vecs.push_back(mk(1,0,U,N,0,100,14,4'b0000,0,0,114,28,114,28,0));
        // fire held with cooldown 2: launches on ticks 1, 4, 7, 10
        vecs.push_back(mk(0,0,R,N,1,100,50,4'b0000,0));
        vecs.push_back(mk(0,1,R,N,0,100,50,4'b0000,0));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b0001,1,0,114,64));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b0001,0,0,118,64));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b0001,0));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b0011,1,1,114,64));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b0011,0));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b0011,0));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b0111,1,2,114,64));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b0111,0));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b0111,0));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b1111,1,3,114,64));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b1111,0));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b1111,0));
        // pool full: no launch; hit frees slot 1, refilled only on the next tick
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b1111,0,0,162,64));
        vecs.push_back(mk(1,1,R,4'b0010,0,100,50,4'b1101,0,1,150,64));
        vecs.push_back(mk(1,1,R,N,0,100,50,4'b1111,1,1,114,64));
        // tank_detroyed clears slots, pending and cooldown
        vecs.push_back(mk(0,1,R,4'b1000,0,100,50,4'b0111,0));
        vecs.push_back(mk(1,1,R,N,1,100,50,4'b0000,0));
        vecs.push_back(mk(0,1,R,N,0,100,50,4'b0000,0));
        vecs.push_back(mk(1,0,R,N,0,100,50,4'b0001,1,0,114,64));
        vecs.push_back(mk(0,1,R,N,0,100,50,4'b0001,0));
        vecs.push_back(mk(0,0,R,N,1,100,50,4'b0000,0));
        vecs.push_back(mk(1,0,R,N,0,100,50,4'b0000,0));
        // non-one-hot dir drops the request
        vecs.push_back(mk(0,1,BAD,N,0,100,50,4'b0000,0));
        vecs.push_back(mk(1,0,BAD,N,0,100,50,4'b0000,0));
        vecs.push_back(mk(1,0,R,N,0,100,50,4'b0000,0));
        vecs.push_back(mk(0,1,R,N,0,100,50,4'b0000,0));
        vecs.push_back(mk(1,0,R,N,0,100,50,4'b0001,1,0,114,64));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // asynchronous reset in the middle of a flight
        refresh_tick = 1'b0; fire = 1'b0; x = 10'd114; y = 10'd64;
        #5 reset = 1'b0;
        #1;
        chk("midrst_active", 200, 64'(active), 64'd0);
        chk("midrst_x_bullet", 200, 64'(x_bullet), 64'd0);
        chk("midrst_y_bullet", 200, 64'(y_bullet), 64'd0);
        chk("midrst_bullet_on", 200, 64'(bullet_on), 64'd0);
        @(negedge clk_50MHz);
        reset = 1'b1;
        apply(mk(0,1,R,N,0,100,50,4'b0000,0), 201);
        apply(mk(1,0,R,N,0,100,50,4'b0001,1,0,114,64), 202);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
